// File: rtl/mem_stage.sv
// MEM stage: issues loads/stores on a valid/ready data bus, formats load data and registers the WB bundle.
// Optional feature: define MEM_MISALIGN_EXC_EN to flag misaligned H/W accesses instead of masking low address bits.
module mem_stage #(
  parameter int XLEN        = 32,
  parameter int RF_AW       = 5,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex2mem_reg_wen,
  input  logic [RF_AW-1:0] ex2mem_reg_waddr,
  input  logic [XLEN-1:0]  ex2mem_alu_out,
  input  logic             ex2mem_mem_rd,
  input  logic             ex2mem_mem_wr,
  input  logic [2:0]       ex2mem_mem_op,
  input  logic [XLEN-1:0]  ex2mem_wdata,
  input  logic             ex2mem_ill_instr,
  output logic             dbus_req,
  output logic             dbus_we,
  output logic [XLEN-1:0]  dbus_addr,
  output logic [XLEN-1:0]  dbus_wdata,
  output logic [3:0]       dbus_wstrb,
  input  logic             dbus_ready,
  input  logic             dbus_rvalid,
  input  logic [XLEN-1:0]  dbus_rdata,
  output logic             mem_stall,
  output logic             mem2wb_reg_wen,
  output logic [RF_AW-1:0] mem2wb_reg_waddr,
  output logic [XLEN-1:0]  mem2wb_reg_wdata,
  output logic             mem2wb_ill_instr,
  output logic             mem2wb_bus_err,
  output logic             mem2wb_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] TMO_MAX = 8'(BUS_TIMEOUT);

  state_t      state_reg, state_next;
  logic [7:0]  tmo_cnt_reg, tmo_cnt_next;
  logic        access, done, abort, misalign, stall_int, tmo_hit;
  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [XLEN-1:0] load_data;
  logic        misalign_reg;

  assign access = ex2mem_mem_rd | ex2mem_mem_wr;
  assign lane   = ex2mem_alu_out[1:0];

`ifdef MEM_MISALIGN_EXC_EN
  assign misalign = access & (((ex2mem_mem_op[1:0] == 2'b01) & lane[0]) |
                              ((ex2mem_mem_op[1:0] == 2'b10) & (lane != 2'b00)));
  assign mem2wb_misalign = misalign_reg;
`else
  assign misalign = 1'b0;
  assign mem2wb_misalign = 1'b0;
`endif

  assign tmo_hit = (state_reg != IDLE) && (tmo_cnt_reg == TMO_MAX);

  always_comb begin
    state_next   = state_reg;
    done         = 1'b0;
    abort        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access && !misalign) begin
          if (dbus_ready) begin
            if (ex2mem_mem_wr) done = 1'b1;
            else               state_next = RESP;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // A timed-out request is withdrawn, so a late ready in that cycle is not an acceptance.
        if (tmo_hit) begin
          abort = 1'b1;
        end else if (dbus_ready) begin
          if (ex2mem_mem_wr) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RESP;
          end
        end
      end
      RESP: begin
        if (dbus_rvalid) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
    tmo_cnt_next = (state_reg == IDLE || done || abort) ? 8'd0 : tmo_cnt_reg + 8'd1;
  end

  assign stall_int = access & !done & !abort & !misalign;
  assign mem_stall = rst_n & stall_int;
  assign dbus_req  = rst_n & access & !misalign & (state_reg != RESP) & !abort;
  assign dbus_we   = ex2mem_mem_wr;
  assign dbus_addr = {ex2mem_alu_out[XLEN-1:2], 2'b00};

  always_comb begin
    dbus_wdata = ex2mem_wdata;
    dbus_wstrb = 4'b1111;
    case (ex2mem_mem_op[1:0])
      2'b00: begin
        dbus_wdata = {4{ex2mem_wdata[7:0]}};
        dbus_wstrb = 4'b0001 << lane;
      end
      2'b01: begin
        dbus_wdata = {2{ex2mem_wdata[15:0]}};
        dbus_wstrb = 4'b0011 << {lane[1], 1'b0};
      end
      default: ;
    endcase
    if (!ex2mem_mem_wr) dbus_wstrb = 4'b0000;
  end

  assign byte_sel = dbus_rdata[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];

  always_comb begin
    case (ex2mem_mem_op)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      tmo_cnt_reg <= 8'd0;
    end else begin
      state_reg   <= state_next;
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end

  // While stalled WB sees a bubble; the real result lands in the done/abort cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem2wb_reg_wen   <= 1'b0;
      mem2wb_reg_waddr <= '0;
      mem2wb_reg_wdata <= '0;
      mem2wb_ill_instr <= 1'b0;
      mem2wb_bus_err   <= 1'b0;
      misalign_reg     <= 1'b0;
    end else if (stall_int) begin
      mem2wb_reg_wen   <= 1'b0;
      mem2wb_reg_waddr <= '0;
      mem2wb_reg_wdata <= '0;
      mem2wb_ill_instr <= 1'b0;
      mem2wb_bus_err   <= 1'b0;
      misalign_reg     <= 1'b0;
    end else begin
      mem2wb_reg_wen   <= ex2mem_reg_wen & !abort & !misalign;
      mem2wb_reg_waddr <= ex2mem_reg_waddr;
      mem2wb_reg_wdata <= ex2mem_mem_rd ? load_data : ex2mem_alu_out;
      mem2wb_ill_instr <= ex2mem_ill_instr;
      mem2wb_bus_err   <= abort;
      misalign_reg     <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, timeout abort, reset mid-access, misalign handling.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex2mem_reg_wen;
  logic [4:0]  ex2mem_reg_waddr;
  logic [31:0] ex2mem_alu_out;
  logic        ex2mem_mem_rd;
  logic        ex2mem_mem_wr;
  logic [2:0]  ex2mem_mem_op;
  logic [31:0] ex2mem_wdata;
  logic        ex2mem_ill_instr;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ready, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic        mem2wb_reg_wen;
  logic [4:0]  mem2wb_reg_waddr;
  logic [31:0] mem2wb_reg_wdata;
  logic        mem2wb_ill_instr, mem2wb_bus_err, mem2wb_misalign;

  int n_chk = 0;
  int n_bad = 0;

  mem_stage #(.XLEN(32), .RF_AW(5), .BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex2mem_reg_wen(ex2mem_reg_wen), .ex2mem_reg_waddr(ex2mem_reg_waddr),
    .ex2mem_alu_out(ex2mem_alu_out), .ex2mem_mem_rd(ex2mem_mem_rd),
    .ex2mem_mem_wr(ex2mem_mem_wr), .ex2mem_mem_op(ex2mem_mem_op),
    .ex2mem_wdata(ex2mem_wdata), .ex2mem_ill_instr(ex2mem_ill_instr),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_ready(dbus_ready),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .mem_stall(mem_stall),
    .mem2wb_reg_wen(mem2wb_reg_wen), .mem2wb_reg_waddr(mem2wb_reg_waddr),
    .mem2wb_reg_wdata(mem2wb_reg_wdata), .mem2wb_ill_instr(mem2wb_ill_instr),
    .mem2wb_bus_err(mem2wb_bus_err), .mem2wb_misalign(mem2wb_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    ex2mem_reg_wen   = 1'b0;
    ex2mem_reg_waddr = 5'd0;
    ex2mem_alu_out   = 32'd0;
    ex2mem_mem_rd    = 1'b0;
    ex2mem_mem_wr    = 1'b0;
    ex2mem_mem_op    = 3'b010;
    ex2mem_wdata     = 32'd0;
    ex2mem_ill_instr = 1'b0;
    dbus_ready       = 1'b0;
    dbus_rvalid      = 1'b0;
    dbus_rdata       = 32'd0;
  endtask

  task automatic drive_mem(input logic rd, input [31:0] addr, input [2:0] op, input [31:0] wd, input [4:0] rd_idx);
    ex2mem_reg_wen   = rd;
    ex2mem_reg_waddr = rd_idx;
    ex2mem_alu_out   = addr;
    ex2mem_mem_rd    = rd;
    ex2mem_mem_wr    = !rd;
    ex2mem_mem_op    = op;
    ex2mem_wdata     = wd;
  endtask

  // Ready after rdy_dly waiting cycles, rvalid after rv_dly RESP cycles.
  task automatic load_xact(input string tag, input [31:0] addr, input [2:0] op, input int rdy_dly,
                           input int rv_dly, input [31:0] rdata, input [31:0] exp);
    int stalls = 0;
    drive_mem(1'b1, addr, op, 32'd0, 5'd9);
    for (int i = 0; i <= rdy_dly; i++) begin
      dbus_ready = (i == rdy_dly);
      #1;
      if (i == 0) begin
        chk({tag, ".addr"}, dbus_addr, addr & 32'hFFFF_FFFC);
        chk({tag, ".we"}, {31'd0, dbus_we}, 32'd0);
      end
      chk({tag, ".req"}, {31'd0, dbus_req}, 32'd1);
      if (mem_stall) stalls++;
      next_cycle();
    end
    dbus_ready = 1'b0;
    for (int j = 0; j <= rv_dly; j++) begin
      dbus_rvalid = (j == rv_dly);
      dbus_rdata  = (j == rv_dly) ? rdata : 32'hDEAD_BEEF;
      #1;
      if (j == 0) chk({tag, ".resp_req"}, {31'd0, dbus_req}, 32'd0);
      if (mem_stall) stalls++;
      next_cycle();
    end
    drive_nop();
    chk({tag, ".stalls"}, stalls, rdy_dly + 1 + rv_dly);
    chk({tag, ".wdata"}, mem2wb_reg_wdata, exp);
    chk({tag, ".wen"}, {31'd0, mem2wb_reg_wen}, 32'd1);
    chk({tag, ".waddr"}, {27'd0, mem2wb_reg_waddr}, 32'd9);
    $display("load %s addr=%h op=%b rdata=%h -> wdata=%h stalls=%0d", tag, addr, op, rdata, mem2wb_reg_wdata, stalls);
  endtask

  task automatic store_xact(input string tag, input [31:0] addr, input [2:0] op, input [31:0] d,
                            input int rdy_dly, input [3:0] exp_strb, input [31:0] exp_wd);
    int stalls = 0;
    drive_mem(1'b0, addr, op, d, 5'd0);
    for (int i = 0; i <= rdy_dly; i++) begin
      dbus_ready = (i == rdy_dly);
      #1;
      if (i == 0) begin
        chk({tag, ".strb"}, {28'd0, dbus_wstrb}, {28'd0, exp_strb});
        chk({tag, ".bwdata"}, dbus_wdata, exp_wd);
        chk({tag, ".we"}, {31'd0, dbus_we}, 32'd1);
      end
      if (mem_stall) stalls++;
      next_cycle();
    end
    drive_nop();
    chk({tag, ".stalls"}, stalls, rdy_dly);
    chk({tag, ".wen"}, {31'd0, mem2wb_reg_wen}, 32'd0);
    chk({tag, ".wbaddr"}, mem2wb_reg_wdata, addr);
    $display("store %s addr=%h op=%b data=%h strb=%b stalls=%0d", tag, addr, op, d, exp_strb, stalls);
  endtask

  initial begin
    int stalls;
    rst_n = 1'b0;
    drive_nop();
    repeat (2) next_cycle();
    chk("rst.wen", {31'd0, mem2wb_reg_wen}, 32'd0);
    chk("rst.wdata", mem2wb_reg_wdata, 32'd0);
    chk("rst.req", {31'd0, dbus_req}, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // Plain ALU result passes straight through.
    ex2mem_reg_wen = 1'b1; ex2mem_reg_waddr = 5'd5; ex2mem_alu_out = 32'h1234_5678; ex2mem_ill_instr = 1'b1;
    #1;
    chk("alu.stall", {31'd0, mem_stall}, 32'd0);
    chk("alu.req", {31'd0, dbus_req}, 32'd0);
    next_cycle();
    drive_nop();
    chk("alu.wdata", mem2wb_reg_wdata, 32'h1234_5678);
    chk("alu.wen", {31'd0, mem2wb_reg_wen}, 32'd1);
    chk("alu.waddr", {27'd0, mem2wb_reg_waddr}, 32'd5);
    chk("alu.ill", {31'd0, mem2wb_ill_instr}, 32'd1);
    $display("alu wdata=%h", mem2wb_reg_wdata);

    load_xact("lb",  32'h0000_1003, 3'b000, 2, 0, 32'h80FF_FF00, 32'hFFFF_FF80);
    load_xact("lhu", 32'h0000_2002, 3'b101, 0, 1, 32'h8001_1234, 32'h0000_8001);
    load_xact("lh",  32'h0000_0010, 3'b001, 1, 2, 32'h1234_8765, 32'hFFFF_8765);
    load_xact("lbu", 32'h0000_5001, 3'b100, 0, 0, 32'h0000_9A00, 32'h0000_009A);
    store_xact("sb", 32'h0000_3001, 3'b000, 32'h0000_00AB, 0, 4'b0010, 32'hABAB_ABAB);
    store_xact("sh", 32'h0000_6002, 3'b001, 32'h1234_BEEF, 1, 4'b1100, 32'hBEEF_BEEF);
    store_xact("sw", 32'h0000_7000, 3'b010, 32'h0102_0304, 3, 4'b1111, 32'h0102_0304);

    // Timeout: ready never comes; 1 IDLE + 4 REQ cycles stall, fifth REQ cycle aborts.
    drive_mem(1'b1, 32'h0000_8000, 3'b010, 32'd0, 5'd3);
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (!mem_stall) break;
      stalls++;
      next_cycle();
    end
    chk("tmo.stalls", stalls, 5);
    chk("tmo.req", {31'd0, dbus_req}, 32'd0);
    next_cycle();
    drive_nop();
    chk("tmo.bus_err", {31'd0, mem2wb_bus_err}, 32'd1);
    chk("tmo.wen", {31'd0, mem2wb_reg_wen}, 32'd0);
    next_cycle();
    chk("tmo.resume", {31'd0, mem2wb_bus_err}, 32'd0);
    $display("timeout stalls=%0d", stalls);

    // Reset asserted while waiting for read data.
    drive_mem(1'b1, 32'h0000_9000, 3'b010, 32'd0, 5'd4);
    dbus_ready = 1'b1;
    next_cycle();
    dbus_ready = 1'b0;
    #1;
    chk("rstresp.stall_pre", {31'd0, mem_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstresp.req", {31'd0, dbus_req}, 32'd0);
    chk("rstresp.stall", {31'd0, mem_stall}, 32'd0);
    next_cycle();
    drive_nop();
    rst_n = 1'b1;
    chk("rstresp.wb_wen", {31'd0, mem2wb_reg_wen}, 32'd0);
    chk("rstresp.wb_wdata", mem2wb_reg_wdata, 32'd0);
    $display("reset mid-RESP done");
    load_xact("post_rst", 32'h0000_0104, 3'b010, 0, 0, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

`ifdef MEM_MISALIGN_EXC_EN
    drive_mem(1'b1, 32'h0000_4002, 3'b010, 32'd0, 5'd6);
    #1;
    chk("mis.req", {31'd0, dbus_req}, 32'd0);
    chk("mis.stall", {31'd0, mem_stall}, 32'd0);
    next_cycle();
    drive_nop();
    chk("mis.flag", {31'd0, mem2wb_misalign}, 32'd1);
    chk("mis.wen", {31'd0, mem2wb_reg_wen}, 32'd0);
    $display("misaligned lw flagged=%0b", mem2wb_misalign);
`else
    load_xact("lw_mis", 32'h0000_4002, 3'b010, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    chk("lw_mis.flag", {31'd0, mem2wb_misalign}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
